// File: rtl/exp_filter_pkg.sv
// Shared definitions for the exponential smoother family: FSM encoding, rounding helper
// and Q0.8 coefficient presets.
package exp_filter_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef logic [1:0] fsm_state_t;

  // Presets assume COEF_W = 8 (alpha = coef / 256).
  localparam logic [7:0] ALPHA_0P01 = 8'd3;
  localparam logic [7:0] ALPHA_0P10 = 8'd26;
  localparam logic [7:0] ALPHA_0P50 = 8'd128;

  // Half an LSB of the Q0.coef_w product, used for round-half-up.
  function automatic int unsigned round_const(input int unsigned coef_w);
    return 32'd1 << (coef_w - 1);
  endfunction

endpackage

// File: rtl/exp_blend_unit.sv
// Combinational blend: picks attack or decay alpha, computes the rounded weighted mix
// of new sample and stored value, clamps to the data range.
module exp_blend_unit #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] old,
  input  logic [COEF_W-1:0] attack_coef,
  input  logic [COEF_W-1:0] decay_coef,
  output logic [DATA_W-1:0] y
);
  import exp_filter_pkg::*;

  localparam int SUM_W = DATA_W + COEF_W + 1;
  localparam logic [SUM_W-1:0] ONE   = SUM_W'(1) << COEF_W;
  localparam logic [SUM_W-1:0] RND   = SUM_W'(round_const(COEF_W));
  localparam logic [SUM_W-1:0] Y_MAX = SUM_W'((1 << DATA_W) - 1);

  logic [COEF_W-1:0] alpha;
  logic [SUM_W-1:0]  alpha_w;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  shifted;

  always_comb begin
    alpha   = (data > old) ? attack_coef : decay_coef;
    alpha_w = SUM_W'(alpha);
    sum     = alpha_w * SUM_W'(data) + (ONE - alpha_w) * SUM_W'(old) + RND;
    shifted = sum >> COEF_W;
    y       = (shifted > Y_MAX) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/exp_smoother_bank.sv
// Multi-bin asymmetric exponential smoother with 2-stage pipeline and clear sweep.
// Optional per-bin peak hold is built when the macro PEAK_HOLD_EN is defined.
module exp_smoother_bank
  import exp_filter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_BINS = 40,
  parameter int COEF_W   = 8,
  parameter int ADDR_W   = 6
`ifdef PEAK_HOLD_EN
  ,
  parameter int HOLD_UPDATES = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [COEF_W-1:0] attack_coef,
  input  logic [COEF_W-1:0] decay_coef,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
`ifdef PEAK_HOLD_EN
  output logic [DATA_W-1:0] out_peak,
`endif
  output fsm_state_t        fsm_state
);

  localparam logic [ADDR_W:0]   BIN_LIMIT = (ADDR_W + 1)'(NUM_BINS);
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(NUM_BINS - 1);

  fsm_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] bin_mem [NUM_BINS];

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] s1_old;
  logic [COEF_W-1:0] s1_attack;
  logic [COEF_W-1:0] s1_decay;

  logic              stall;
  logic              accept;
  logic              in_range;
  logic              s2_fire;
  logic              fwd;
  logic [DATA_W-1:0] old_mem;
  logic [DATA_W-1:0] old_next;
  logic [DATA_W-1:0] y;

  // Handshake: a transfer happens on an edge where valid && ready; valid must stay high and
  // payload stable until that edge; ready may depend on state and out_ready only.
  always_comb begin
    stall    = out_valid && !out_ready;
    in_ready = (state == ST_RUN) && !stall;
    accept   = in_valid && in_ready;
    in_range = {1'b0, in_addr} < BIN_LIMIT;
    s2_fire  = s1_valid && !stall;
    fwd      = s2_fire && (s1_addr == in_addr);
    old_mem  = '0;
    if (in_range) old_mem = bin_mem[in_addr];
    old_next = fwd ? y : old_mem;
  end

  assign fsm_state = state;

  exp_blend_unit #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_blend (
    .data       (s1_data),
    .old        (s1_old),
    .attack_coef(s1_attack),
    .decay_coef (s1_decay),
    .y          (y)
  );

`ifdef PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_UPDATES + 1);

  logic [DATA_W-1:0] peak_mem [NUM_BINS];
  logic [HOLD_W-1:0] hold_mem [NUM_BINS];
  logic [DATA_W-1:0] s1_peak;
  logic [HOLD_W-1:0] s1_hold;
  logic [DATA_W-1:0] peak_new;
  logic [HOLD_W-1:0] hold_new;
  logic [DATA_W-1:0] peak_next;
  logic [HOLD_W-1:0] hold_next;
  logic [DATA_W-1:0] peak_dec;

  always_comb begin
    peak_dec = s1_peak - 1'b1;
    if (y >= s1_peak) begin
      peak_new = y;
      hold_new = HOLD_W'(HOLD_UPDATES);
    end else if (s1_hold != '0) begin
      peak_new = s1_peak;
      hold_new = s1_hold - 1'b1;
    end else begin
      peak_new = (peak_dec > y) ? peak_dec : y;
      hold_new = '0;
    end
    peak_next = '0;
    hold_next = '0;
    if (fwd) begin
      peak_next = peak_new;
      hold_next = hold_new;
    end else if (in_range) begin
      peak_next = peak_mem[in_addr];
      hold_next = hold_mem[in_addr];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == LAST_BIN) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: if (clr) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!s1_valid && (!out_valid || out_ready)) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_data   <= '0;
      s1_old    <= '0;
      s1_attack <= '0;
      s1_decay  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
`ifdef PEAK_HOLD_EN
      s1_peak   <= '0;
      s1_hold   <= '0;
      out_peak  <= '0;
`endif
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_addr <= s1_addr;
        out_data <= y;
`ifdef PEAK_HOLD_EN
        out_peak <= peak_new;
`endif
      end
      // Out-of-range bins are taken off the input but never enter the pipe.
      s1_valid <= accept && in_range;
      if (accept) begin
        s1_addr   <= in_addr;
        s1_data   <= in_data;
        s1_old    <= old_next;
        s1_attack <= attack_coef;
        s1_decay  <= decay_coef;
`ifdef PEAK_HOLD_EN
        s1_peak   <= peak_next;
        s1_hold   <= hold_next;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR && !clr) begin
      bin_mem[cnt] <= '0;
`ifdef PEAK_HOLD_EN
      peak_mem[cnt] <= '0;
      hold_mem[cnt] <= '0;
`endif
    end
    if (s2_fire) begin
      bin_mem[s1_addr] <= y;
`ifdef PEAK_HOLD_EN
      peak_mem[s1_addr] <= peak_new;
      hold_mem[s1_addr] <= hold_new;
`endif
    end
  end

endmodule

// File: tb/tb_exp_smoother_bank.sv
// Directed bench for exp_smoother_bank: reset sweep, attack/decay math, forwarding,
// stall, out-of-range discard and clear. Peak-hold checks build with PEAK_HOLD_EN.
module tb_exp_smoother_bank;
  import exp_filter_pkg::*;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [COEF_W-1:0] attack_coef;
  logic [COEF_W-1:0] decay_coef;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
`ifdef PEAK_HOLD_EN
  logic [DATA_W-1:0] out_peak;
`endif
  fsm_state_t        fsm_state;

  int n_pass   = 0;
  int n_checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  exp_smoother_bank dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .attack_coef(attack_coef),
    .decay_coef (decay_coef),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
`ifdef PEAK_HOLD_EN
    .out_peak   (out_peak),
`endif
    .fsm_state  (fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one sample and return the output seen one edge after acceptance.
  task automatic do_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output logic ov, output logic [ADDR_W-1:0] oa,
                        output logic [DATA_W-1:0] od);
    int n;
    n = 0;
    @(negedge clk);
    in_addr = a; in_data = d; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    ov = out_valid; oa = out_addr; od = out_data;
  endtask

  task automatic test_reset;
    int zeros;
    logic ov; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_addr, out_data} !== '0)
      $display("FAIL reset_outputs: got rdy=%0b ov=%0b addr=%0d data=%0d required all 0",
               in_ready, out_valid, out_addr, out_data);
    else n_pass++;
    n_checks++;
    if (fsm_state !== ST_CLEAR) $display("FAIL reset_state: got %0d required %0d", fsm_state, ST_CLEAR);
    else n_pass++;
    rst = 1'b0;
    zeros = 0;
    while (!in_ready && zeros < 200) begin
      zeros++;
      @(negedge clk);
    end
    n_checks++;
    if (zeros !== 40) $display("FAIL reset_sweep_len: got %0d required 40", zeros);
    else n_pass++;
    // alpha = 0 probes return the stored value unchanged.
    attack_coef = '0; decay_coef = '0;
    for (int b = 0; b < 40; b++) begin
      do_one(ADDR_W'(b), 8'd77, ov, oa, od);
      n_checks++;
      if (ov !== 1'b1 || oa !== ADDR_W'(b) || od !== 8'd0)
        $display("FAIL reset_probe bin %0d: got ov=%0b addr=%0d data=%0d required 1/%0d/0",
                 b, ov, oa, od, b);
      else n_pass++;
    end
  endtask

  task automatic test_attack;
    attack_coef = ALPHA_0P10; decay_coef = '0;
    @(negedge clk);
    in_addr = 6'd0; in_data = 8'd200; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL attack_ready: got %0b required 1", in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL attack_early: got out_valid=%0b required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd20 || out_addr !== 6'd0)
      $display("FAIL attack_out: got ov=%0b data=%0d addr=%0d required 1/20/0", out_valid, out_data, out_addr);
    else n_pass++;
  endtask

  task automatic test_decay;
    logic ov; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od;
    attack_coef = 8'd255; decay_coef = '0;
    do_one(6'd5, 8'd100, ov, oa, od);
    n_checks++;
    if (ov !== 1'b1 || od !== 8'd100) $display("FAIL decay_preload: got ov=%0b data=%0d required 1/100", ov, od);
    else n_pass++;
    attack_coef = '0; decay_coef = ALPHA_0P01;
    do_one(6'd5, 8'd0, ov, oa, od);
    n_checks++;
    if (ov !== 1'b1 || od !== 8'd99 || oa !== 6'd5)
      $display("FAIL decay_first: got ov=%0b data=%0d addr=%0d required 1/99/5", ov, od, oa);
    else n_pass++;
    do_one(6'd5, 8'd0, ov, oa, od);
    n_checks++;
    if (ov !== 1'b1 || od !== 8'd98) $display("FAIL decay_second: got ov=%0b data=%0d required 1/98", ov, od);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic ov; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od;
    attack_coef = ALPHA_0P50; decay_coef = '0;
    @(negedge clk);
    in_addr = 6'd3; in_data = 8'd200; in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %0b required 1", in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd100 || out_addr !== 6'd3)
      $display("FAIL b2b_first: got ov=%0b data=%0d addr=%0d required 1/100/3", out_valid, out_data, out_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd150 || out_addr !== 6'd3)
      $display("FAIL b2b_second: got ov=%0b data=%0d addr=%0d required 1/150/3", out_valid, out_data, out_addr);
    else n_pass++;
    attack_coef = '0; decay_coef = '0;
    do_one(6'd3, 8'd0, ov, oa, od);
    n_checks++;
    if (ov !== 1'b1 || od !== 8'd150) $display("FAIL b2b_stored: got ov=%0b data=%0d required 1/150", ov, od);
    else n_pass++;
  endtask

  task automatic test_out_of_range;
    attack_coef = 8'd255; decay_coef = '0;
    @(negedge clk);
    in_addr = 6'd45; in_data = 8'd200; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL oor_ready: got %0b required 1", in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL oor_no_output cycle %0d: got out_valid=%0b required 0", i, out_valid);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    attack_coef = 8'd255; decay_coef = '0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(DATA_W'(10 * (i + 1)));
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin : driver
        int n;
        for (int i = 0; i < 4; i++) begin
          in_addr = ADDR_W'(10 + i); in_data = DATA_W'(10 * (i + 1)); in_valid = 1'b1;
          n = 0;
          #1;
          while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int n;
        int got;
        logic [DATA_W-1:0] hd;
        logic [ADDR_W-1:0] ha;
        logic [DATA_W-1:0] e;
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        hd = out_data; ha = out_addr;
        n_checks++;
        if (hd !== 8'd10 || ha !== 6'd10) $display("FAIL stall_head: got data=%0d addr=%0d required 10/10", hd, ha);
        else n_pass++;
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== hd || out_addr !== ha || in_ready !== 1'b0)
            $display("FAIL stall_hold: got ov=%0b data=%0d addr=%0d rdy=%0b required 1/%0d/%0d/0",
                     out_valid, out_data, out_addr, in_ready, hd, ha);
          else n_pass++;
        end
        out_ready = 1'b1;
        got = 0; n = 0;
        while (got < 4 && n < 100) begin
          if (out_valid) begin
            e = exp_q.pop_front();
            n_checks++;
            if (out_data !== e || out_addr !== ADDR_W'(10 + got))
              $display("FAIL stall_order %0d: got data=%0d addr=%0d required %0d/%0d",
                       got, out_data, out_addr, e, 10 + got);
            else n_pass++;
            got++;
          end
          @(negedge clk);
          n++;
        end
        n_checks++;
        if (got !== 4) $display("FAIL stall_count: got %0d outputs required 4", got);
        else n_pass++;
      end
    join
  endtask

  task automatic test_clear;
    int zeros;
    logic ov; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od;
    attack_coef = 8'd255; decay_coef = '0;
    @(negedge clk);
    in_addr = 6'd20; in_data = 8'd50; in_valid = 1'b1;
    @(negedge clk);
    in_addr = 6'd21; in_data = 8'd60; clr = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL clr_accept_same_edge: got rdy=%0b required 1", in_ready);
    else n_pass++;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd50 || out_addr !== 6'd20 || in_ready !== 1'b0)
      $display("FAIL clr_drain_first: got ov=%0b data=%0d addr=%0d rdy=%0b required 1/50/20/0",
               out_valid, out_data, out_addr, in_ready);
    else n_pass++;
    n_checks++;
    if (fsm_state !== ST_DRAIN) $display("FAIL clr_state: got %0d required %0d", fsm_state, ST_DRAIN);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd60 || out_addr !== 6'd21)
      $display("FAIL clr_drain_second: got ov=%0b data=%0d addr=%0d required 1/60/21", out_valid, out_data, out_addr);
    else n_pass++;
    @(negedge clk);
    zeros = 0;
    while (!in_ready && zeros < 200) begin
      zeros++;
      @(negedge clk);
    end
    n_checks++;
    if (zeros !== 40) $display("FAIL clr_sweep_len: got %0d required 40", zeros);
    else n_pass++;
    attack_coef = ALPHA_0P10; decay_coef = '0;
    do_one(6'd0, 8'd200, ov, oa, od);
    n_checks++;
    if (ov !== 1'b1 || od !== 8'd20 || oa !== 6'd0)
      $display("FAIL clr_after: got ov=%0b data=%0d addr=%0d required 1/20/0", ov, od, oa);
    else n_pass++;
    attack_coef = '0; decay_coef = '0;
    do_one(6'd21, 8'd9, ov, oa, od);
    n_checks++;
    if (ov !== 1'b1 || od !== 8'd0) $display("FAIL clr_bin21: got ov=%0b data=%0d required 1/0", ov, od);
    else n_pass++;
  endtask

`ifdef PEAK_HOLD_EN
  task automatic test_peak_hold;
    logic ov; logic [ADDR_W-1:0] oa; logic [DATA_W-1:0] od;
    logic [DATA_W-1:0] exp_peak;
    attack_coef = 8'd255; decay_coef = 8'd255;
    do_one(6'd30, 8'd200, ov, oa, od);
    n_checks++;
    if (od !== 8'd199 || out_peak !== 8'd199)
      $display("FAIL peak_load: got data=%0d peak=%0d required 199/199", od, out_peak);
    else n_pass++;
    for (int u = 1; u <= 10; u++) begin
      do_one(6'd30, 8'd0, ov, oa, od);
      exp_peak = (u <= 8) ? 8'd199 : DATA_W'(199 - (u - 8));
      n_checks++;
      if (out_peak !== exp_peak) $display("FAIL peak_update %0d: got %0d required %0d", u, out_peak, exp_peak);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    rst = 1'b1; clr = 1'b0;
    attack_coef = '0; decay_coef = '0;
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_attack();
    test_decay();
    test_back_to_back();
    test_out_of_range();
    test_stall();
    test_clear();
`ifdef PEAK_HOLD_EN
    test_peak_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
